// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU load/store path. Accepts one read or
//   write request at a time, waits WAIT_CYCLES extra cycles, then performs
//   the access against an internal RAM (or the MMIO register at the all-ones
//   address) and presents the result on a held response handshake.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low
//   req_valid  : request present
//   req_ready  : high only while idle (Moore)
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : response present, held until rsp_ready
//   rsp_ready  : response consumed
//   rsp_rdata  : read data (0 for write responses)
//   sw         : board switches, read through the MMIO address
//   led        : LED register, written through the MMIO address
module mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic [9:0]            sw,
    output logic [9:0]            led
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MMIO_ADDR = '1;
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [9:0]            led_q, led_d;
    logic                  ram_we;

    // RAM contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        ram_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Counter saturates at zero; the access happens on the edge
                // where it is already zero.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    if (wr_q) begin
                        rdata_d = '0;
                        if (addr_q == MMIO_ADDR) begin
                            led_d = wdata_q[9:0];
                        end else begin
                            ram_we = 1'b1;
                        end
                    end else if (addr_q == MMIO_ADDR) begin
                        rdata_d = {{(DATA_WIDTH-10){1'b0}}, sw};
                    end else begin
                        rdata_d = ram[addr_q];
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    // Reset only ever holds the FSM out of ACCESS, so a write interrupted by
    // reset never reaches this port.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [7:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_rdata [3];
    logic [9:0]  sw        [3];
    logic [9:0]  led       [3];

    always #5 clk = ~clk;

    // Three instances: WAIT_CYCLES = 0, 1, 3
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            mem_responder #(
                .DATA_WIDTH (16),
                .ADDR_WIDTH (8),
                .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_write (req_write[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_ready (rsp_ready[g]),
                .rsp_rdata (rsp_rdata[g]),
                .sw        (sw[g]),
                .led       (led[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt [3];
    int acc_time [3][64];

    // Reference model: word memory with known-flags and the LED register
    logic [15:0] mdl_mem   [3][256];
    bit          mdl_known [3][256];
    logic [9:0]  mdl_led   [3];

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [15:0] exp_rdata(input int k, input bit wr, input logic [7:0] a);
        if (wr) return 16'h0000;
        if (a == 8'hFF) return {6'b0, sw[k]};
        return mdl_mem[k][a];
    endfunction

    function automatic bit exp_known(input int k, input bit wr, input logic [7:0] a);
        return wr || (a == 8'hFF) || mdl_known[k][a];
    endfunction

    task automatic model_apply(input int k, input bit wr, input logic [7:0] a, input logic [15:0] wd);
        if (wr) begin
            if (a == 8'hFF) mdl_led[k] = wd[9:0];
            else begin
                mdl_mem[k][a]   = wd;
                mdl_known[k][a] = 1'b1;
            end
        end
    endtask

    // Acceptance monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) begin
                acc_time[k][acc_cnt[k] % 64] <= cyc;
                acc_cnt[k] <= acc_cnt[k] + 1;
            end
        end
    end

    // One complete transaction with optional response backpressure
    task automatic txn(input int k, input bit wr, input logic [7:0] a, input logic [15:0] wd, input int hold);
        int          edges;
        logic [15:0] exp;
        bit          known;
        @(negedge clk);
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready dut%0d: got %b expected 1", k, req_ready[k]);
        end
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        rsp_ready[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        exp   = exp_rdata(k, wr, a);
        known = exp_known(k, wr, a);
        model_apply(k, wr, a, wd);
        edges = 0;
        while (rsp_valid[k] !== 1'b1 && edges < 40) begin
            checks++;
            if (req_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready dut%0d: got %b expected 0", k, req_ready[k]);
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != wc(k) + 1) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d edges expected %0d", k, edges, wc(k) + 1);
        end
        if (!known) exp = rsp_rdata[k];
        else begin
            checks++;
            if (rsp_rdata[k] !== exp) begin
                errors++;
                $display("FAIL rdata dut%0d addr %h wr %0d: got %h expected %h", k, a, wr, rsp_rdata[k], exp);
            end
        end
        checks++;
        if (led[k] !== mdl_led[k]) begin
            errors++;
            $display("FAIL led dut%0d: got %h expected %h", k, led[k], mdl_led[k]);
        end
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid[k] !== 1'b1 || req_ready[k] !== 1'b0 || rsp_rdata[k] !== exp) begin
                errors++;
                $display("FAIL rsp_hold dut%0d: got valid %b ready %b data %h expected 1 0 %h",
                         k, rsp_valid[k], req_ready[k], rsp_rdata[k], exp);
            end
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL release dut%0d: got valid %b ready %b expected 0 1", k, rsp_valid[k], req_ready[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 8'h00;
            req_wdata[k] = 16'h0; rsp_ready[k] = 1'b0; sw[k] = 10'h0; mdl_led[k] = 10'h0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 16'h0 || led[k] !== 10'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got ready %b valid %b data %h led %h expected 1 0 0000 000",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], led[k]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        txn(1, 1'b1, 8'h05, 16'h1234, 0);
        txn(1, 1'b0, 8'h05, 16'h0000, 0);
    endtask

    task automatic test_latency();
        txn(0, 1'b1, 8'h10, 16'(($urandom)), 0);
        txn(0, 1'b0, 8'h10, 16'h0000, 1);
        txn(2, 1'b1, 8'h10, 16'(($urandom)), 0);
        txn(2, 1'b0, 8'h10, 16'h0000, 1);
    endtask

    task automatic test_mmio();
        txn(1, 1'b1, 8'hFF, 16'h03FF, 0);
        sw[1] = 10'h2A5;
        txn(1, 1'b0, 8'hFF, 16'h0000, 0);
        checks++;
        if (led[1] !== 10'h3FF) begin
            errors++;
            $display("FAIL mmio_led dut1: got %h expected 3ff", led[1]);
        end
    endtask

    task automatic test_backpressure();
        int          start;
        int          n;
        logic [15:0] exp;
        start = acc_cnt[1];
        exp = exp_rdata(1, 1'b0, 8'h05);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h05; rsp_ready[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        repeat (5) begin
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp || req_ready[1] !== 1'b0 || acc_cnt[1] != start + 1) begin
                errors++;
                $display("FAIL backpressure dut1: got valid %b data %h ready %b accepts %0d expected 1 %h 0 %0d",
                         rsp_valid[1], rsp_rdata[1], req_ready[1], acc_cnt[1] - start, exp, 1);
            end
            @(posedge clk); @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b1 || acc_cnt[1] != start + 1) begin
            errors++;
            $display("FAIL bp_no_early_accept dut1: got ready %b accepts %0d expected 1 1", req_ready[1], acc_cnt[1] - start);
        end
        @(posedge clk); @(negedge clk);
        req_valid[1] = 1'b0;
        checks++;
        if (acc_cnt[1] != start + 2 || req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_reaccept dut1: got accepts %0d ready %b expected 2 0", acc_cnt[1] - start, req_ready[1]);
        end
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp) begin
            errors++;
            $display("FAIL bp_second_rsp dut1: got valid %b data %h expected 1 %h", rsp_valid[1], rsp_rdata[1], exp);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back(input int k);
        bit          wr [4];
        logic [7:0]  a  [4];
        logic [15:0] d  [4];
        logic [15:0] exp;
        bit          known;
        int          start;
        int          n;
        int          gap;
        a[0] = 8'($urandom_range(0, 7)); a[1] = a[0];
        a[2] = a[0] + 8'd8;              a[3] = a[2];
        for (int i = 0; i < 4; i++) begin
            wr[i] = (i % 2 == 0);
            d[i]  = 16'($urandom);
        end
        start = acc_cnt[k];
        @(negedge clk);
        rsp_ready[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid[k] = 1'b1; req_write[k] = wr[i]; req_addr[k] = a[i]; req_wdata[k] = d[i];
            n = 0;
            while (req_ready[k] !== 1'b1 && n < 40) begin
                @(posedge clk); @(negedge clk); n++;
            end
            @(posedge clk); @(negedge clk);
            exp   = exp_rdata(k, wr[i], a[i]);
            known = exp_known(k, wr[i], a[i]);
            model_apply(k, wr[i], a[i], d[i]);
            n = 0;
            while (rsp_valid[k] !== 1'b1 && n < 40) begin
                @(posedge clk); @(negedge clk); n++;
            end
            checks++;
            if (rsp_valid[k] !== 1'b1 || (known && rsp_rdata[k] !== exp)) begin
                errors++;
                $display("FAIL b2b_rsp dut%0d txn%0d: got valid %b data %h expected 1 %h", k, i, rsp_valid[k], rsp_rdata[k], exp);
            end
        end
        req_valid[k] = 1'b0;
        @(posedge clk); @(negedge clk);
        rsp_ready[k] = 1'b0;
        checks++;
        if (acc_cnt[k] - start != 4) begin
            errors++;
            $display("FAIL b2b_accepts dut%0d: got %0d expected 4", k, acc_cnt[k] - start);
        end
        for (int i = 1; i < 4; i++) begin
            gap = acc_time[k][(start + i) % 64] - acc_time[k][(start + i - 1) % 64];
            checks++;
            if (gap != wc(k) + 3) begin
                errors++;
                $display("FAIL b2b_spacing dut%0d gap%0d: got %0d expected %0d", k, i, gap, wc(k) + 3);
            end
        end
    endtask

    task automatic test_reset_access();
        logic [15:0] prior;
        prior = 16'h5A5A ^ 16'($urandom_range(0, 255));
        txn(2, 1'b1, 8'h20, prior, 0);
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 8'h20; req_wdata[2] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) mdl_led[k] = 10'h0;
        checks++;
        if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1 || led[2] !== 10'h0 || led[1] !== 10'h0) begin
            errors++;
            $display("FAIL reset_access: got valid %b ready %b led2 %h led1 %h expected 0 1 000 000",
                     rsp_valid[2], req_ready[2], led[2], led[1]);
        end
        @(negedge clk);
        reset = 1'b1;
        txn(2, 1'b0, 8'h20, 16'h0000, 0);
    endtask

    task automatic test_reset_resp();
        int n;
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h05; rsp_ready[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 16'h0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_resp dut1: got valid %b data %h ready %b expected 0 0000 1",
                     rsp_valid[1], rsp_rdata[1], req_ready[1]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                case ($urandom_range(0, 4))
                    0, 1, 2: a = 8'($urandom_range(0, 7));
                    3:       a = 8'hFF;
                    default: a = 8'h10;
                endcase
                sw[k] = 10'($urandom);
                txn(k, 1'($urandom_range(0, 1)), a, 16'($urandom), int'($urandom_range(0, 2)));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
        test_reset();
        test_write_read();
        test_latency();
        test_mmio();
        test_backpressure();
        for (int k = 0; k < 3; k++) test_back_to_back(k);
        test_reset_access();
        test_reset_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the RISC CPU's load/store path. Accepts one read or write request at a time over a valid/ready handshake and services it against an internal 2^ADDR_WIDTH x DATA_WIDTH RAM after a programmable number of wait cycles. Returns the result over a held response handshake. The all-ones address is a memory-mapped I/O register: reads return the board switches, writes drive the board LEDs. Sits between the CPU controller FSM and on-chip memory/board I/O.

## Interface
- DATA_WIDTH, 16, word width of requests, responses and RAM
- ADDR_WIDTH, 8, request address width; RAM depth 2^ADDR_WIDTH (the top word is shadowed by MMIO)
- WAIT_CYCLES, 1, extra cycles spent in ACCESS before the RAM operation; legal range 0..15
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately on assertion
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response present; held until consumed
- rsp_ready  input  1  CPU consumes the response
- rsp_rdata  output  DATA_WIDTH  read data; 0 for write responses
- sw  input  10  board switches, read through MMIO
- led  output  10  LED register, written through MMIO

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid & req_ready, latch req_write, req_addr and req_wdata.
  - Load the wait counter with WAIT_CYCLES and go to ACCESS.
- **ACCESS**
  - req_ready=0.
  - While the counter is nonzero, decrement it each cycle.
  - On the edge where the counter is 0, perform the operation and go to RESP:
    - write, addr != all-ones: RAM[addr] <= wdata.
    - write, addr == all-ones: led <= wdata[9:0]; RAM untouched.
    - read, addr != all-ones: rsp_rdata <= RAM[addr].
    - read, addr == all-ones: rsp_rdata <= {zeros, sw}, with sw sampled at this edge.
    - any write: rsp_rdata <= 0.
- **RESP**
  - rsp_valid=1, req_ready=0.
  - rsp_rdata is held stable.
  - On rsp_ready=1, go to IDLE at the next edge.
- req_valid seen while not in IDLE is ignored. The CPU holds its request until req_ready; the responder never double-accepts.
- Reads after writes to the same address return the new data; there is no bypass hazard because only one transaction is in flight.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, led=0, wait counter=0.
  - Latched request fields are cleared to 0.
- Acceptance edge E0:
  - The RAM/MMIO operation occurs at edge E0+WAIT_CYCLES+1.
  - rsp_valid is high from just after that edge.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles: accept, ACCESS cycles, one RESP cycle with rsp_ready=1, then back in IDLE.
- req_ready is Moore, high exactly in IDLE. A request presented in the IDLE cycle that follows RESP is accepted.
- rsp_valid and rsp_rdata do not depend combinationally on rsp_ready.
- Backpressure: if rsp_ready=0, the FSM stays in RESP indefinitely with outputs frozen.
- Reset asserted mid-ACCESS:
  - A pending write is dropped; RAM is unchanged unless the write edge already occurred.
  - led returns to 0 and the FSM returns to IDLE.
- Reset asserted in RESP: rsp_valid drops asynchronously.
- Counter arithmetic: 4-bit down-counter, no wrap (it stops at 0).

## Test plan
- WAIT_CYCLES=1: write 0x1234 to addr 0x05, then read 0x05 -> the read response has rsp_rdata=0x1234, and rsp_valid rises 2 cycles after each acceptance edge.
- WAIT_CYCLES=0 and 3: single read of a preloaded addr 0x10 -> rsp_valid asserts 1 and 4 cycles after acceptance respectively; req_ready is low throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata are stable for all 5 cycles. A req_valid held high the whole time is not accepted until the cycle after rsp_ready=1.
- MMIO: write 0x03FF to 0xFF -> led=0x3FF and RAM[0xFF] is unchanged. Set sw=0x2A5 and read 0xFF -> rsp_rdata=0x02A5. A write response returns rsp_rdata=0.
- Reset mid-ACCESS with WAIT_CYCLES=3: a write of 0xBEEF to 0x20 is interrupted by reset 1 cycle after acceptance -> rsp_valid=0, req_ready=1, led=0. After reset, a read of 0x20 returns the prior value, not 0xBEEF.
- Back-to-back: 4 alternating write/read transactions with rsp_ready tied high -> each is accepted exactly once, and the spacing is WAIT_CYCLES+3 cycles.
